// File: rtl/cci_mpf_prim_scoreboard_deq_ctrl.sv
// Dequeue controller: drains the oldest scoreboard port into a small output
// FIFO and presents one in-order ready/valid stream to the client.
//
// Ports:
//   clk, reset                   single clock, synchronous active-high reset
//   sb_notEmpty[0:1]             scoreboard port i holds the oldest entry
//   sb_first / sb_firstMeta      scoreboard port i data / meta
//   sb_deq_en[1:0]               dequeue strobe per port (combinational)
//   hold                         stop draining the scoreboard; FIFO still drains
//   out_valid/out_data/out_meta  FIFO head
//   out_rdy                      client accepts the head this cycle
//   fifo_cnt                     occupied FIFO entries
//   err_dual                     sticky: both ports reported notEmpty together
module cci_mpf_prim_scoreboard_deq_ctrl #(
   parameter int N_DATA_BITS    = 64,
   parameter int N_META_BITS    = 1,
   parameter int OUT_FIFO_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [1:0]                       sb_notEmpty,
   input  logic [N_DATA_BITS-1:0]           sb_first [0:1],
   input  logic [N_META_BITS-1:0]           sb_firstMeta [0:1],
   output logic [1:0]                       sb_deq_en,
   input  logic                             hold,
   output logic                             out_valid,
   output logic [N_DATA_BITS-1:0]           out_data,
   output logic [N_META_BITS-1:0]           out_meta,
   input  logic                             out_rdy,
   output logic [$clog2(OUT_FIFO_DEPTH):0]  fifo_cnt,
   output logic                             err_dual
);

   localparam int PW = $clog2(OUT_FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = N_DATA_BITS + N_META_BITS;
   localparam logic [CW-1:0] DEPTH = CW'(OUT_FIFO_DEPTH);

   logic [EW-1:0] mem [OUT_FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          pop;
   logic          space;
   logic          sel;
   logic          take;
   logic [EW-1:0] wr_ent;
   logic [EW-1:0] rd_ent;

   assign out_valid = (fifo_cnt != '0);

   always_comb begin
      pop   = out_valid && out_rdy;
      // A pop in the same cycle frees the slot the push lands in.
      space = (fifo_cnt < DEPTH) || pop;
      // Port 1 wins, matching the scoreboard's own priority.
      sel   = sb_notEmpty[1];
      take  = !reset && !hold && space && (|sb_notEmpty);
      sb_deq_en = {take && sel, take && !sel};
      wr_ent = sel ? {sb_firstMeta[1], sb_first[1]}
                   : {sb_firstMeta[0], sb_first[0]};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fifo_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         err_dual <= 1'b0;
      end else begin
         if (take) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         fifo_cnt <= fifo_cnt + CW'(take) - CW'(pop);
         if (sb_notEmpty[0] && sb_notEmpty[1]) err_dual <= 1'b1;
      end
   end

   // Storage needs no reset; take is already gated by reset.
   always_ff @(posedge clk) begin
      if (take) mem[wr_ptr] <= wr_ent;
   end

   assign rd_ent   = mem[rd_ptr];
   assign out_data = rd_ent[N_DATA_BITS-1:0];
   assign out_meta = rd_ent[EW-1:N_DATA_BITS];

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!reset) begin
         if (pop && (fifo_cnt == '0))
            $fatal(1, "deq_ctrl: pop from empty FIFO");
         if (take && !pop && (fifo_cnt == DEPTH))
            $fatal(1, "deq_ctrl: push into full FIFO");
      end
   end
`endif

endmodule

// File: tb/tb_cci_mpf_prim_scoreboard_deq_ctrl.sv
// Bench for the scoreboard dequeue controller: directed scenarios plus
// random traffic checked against a queue-based reference model.
module tb_cci_mpf_prim_scoreboard_deq_ctrl;

   localparam int DEPTH = 4;

   logic        clk;
   logic        reset;
   logic [1:0]  sb_notEmpty;
   logic [63:0] sb_first [0:1];
   logic [0:0]  sb_firstMeta [0:1];
   logic [1:0]  sb_deq_en;
   logic        hold;
   logic        out_valid;
   logic [63:0] out_data;
   logic [0:0]  out_meta;
   logic        out_rdy;
   logic [2:0]  fifo_cnt;
   logic        err_dual;

   cci_mpf_prim_scoreboard_deq_ctrl #(
      .N_DATA_BITS(64), .N_META_BITS(1), .OUT_FIFO_DEPTH(DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .sb_notEmpty(sb_notEmpty),
      .sb_first(sb_first), .sb_firstMeta(sb_firstMeta),
      .sb_deq_en(sb_deq_en), .hold(hold), .out_valid(out_valid),
      .out_data(out_data), .out_meta(out_meta), .out_rdy(out_rdy),
      .fifo_cnt(fifo_cnt), .err_dual(err_dual)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [64:0] q [$];
   logic err_exp = 1'b0;
   logic mon_en = 1'b0;
   logic last_take = 1'b0;

   task automatic check(input string name, input logic [64:0] act,
                        input logic [64:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: DUT state is compared against the model on every falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         check("fifo_cnt", 65'(fifo_cnt), 65'(q.size()));
         check("out_valid", 65'(out_valid), 65'(q.size() != 0));
         check("err_dual", 65'(err_dual), 65'(err_exp));
         if (out_valid && q.size() != 0) begin
            check("out_data", 65'(out_data), 65'(q[0][63:0]));
            check("out_meta", 65'(out_meta), 65'(q[0][64]));
            if (out_rdy) void'(q.pop_front());
         end
      end
   end

   // One clock of stimulus; after the monitor has retired this cycle's pop,
   // the model decides whether the scoreboard should be dequeued.
   task automatic cyc(input logic rst, input logic [1:0] ne,
                      input logic [63:0] d0, input logic [63:0] d1,
                      input logic m0, input logic m1,
                      input logic hd, input logic rdy);
      logic exp_take;
      logic [1:0] exp_en;
      @(posedge clk); #1;
      reset = rst; sb_notEmpty = ne; hold = hd; out_rdy = rdy;
      sb_first[0] = d0; sb_first[1] = d1;
      sb_firstMeta[0] = m0; sb_firstMeta[1] = m1;
      @(negedge clk); #1;
      exp_take = !rst && !hd && (ne != 2'b00) && (q.size() < DEPTH);
      exp_en = !exp_take ? 2'b00 : (ne[1] ? 2'b10 : 2'b01);
      check("sb_deq_en", 65'(sb_deq_en), 65'(exp_en));
      last_take = exp_take;
      if (rst) begin
         q.delete();
         err_exp = 1'b0;
      end else begin
         if (ne == 2'b11) err_exp = 1'b1;
         if (exp_take) q.push_back(ne[1] ? {m1, d1} : {m0, d0});
      end
   endtask

   task automatic idle(input int n, input logic rdy);
      for (int i = 0; i < n; i++) cyc(0, 2'b00, 0, 0, 0, 0, 0, rdy);
   endtask

   initial begin
      reset = 1'b1; sb_notEmpty = 2'b00; hold = 1'b0; out_rdy = 1'b0;
      sb_first[0] = '0; sb_first[1] = '0;
      sb_firstMeta[0] = '0; sb_firstMeta[1] = '0;

      // Reset with port 1 offering: no dequeue allowed.
      for (int i = 0; i < 3; i++) cyc(1, 2'b10, 0, 64'h77, 0, 1, 0, 1);
      mon_en = 1'b1;

      // Single entry on port 0.
      cyc(0, 2'b01, 64'hA5, 0, 1, 0, 0, 1);
      idle(3, 1);

      // Backpressure: entry re-offered until taken, client stalled 6 cycles.
      begin
         int idx = 1;
         for (int c = 0; c < 30 && idx <= 6; c++) begin
            cyc(0, 2'b01, 64'(idx), 0, idx[0], 0, 0, c >= 6);
            if (last_take) idx++;
         end
         check("bp_all_taken", 65'(idx), 65'd7);
      end
      idle(6, 1);

      // Alternating ports with distinct meta.
      for (int i = 0; i < 8; i++)
         cyc(0, i[0] ? 2'b01 : 2'b10, 64'(100 + i), 64'(200 + i),
             1'b1, 1'b0, 0, 1);
      idle(3, 1);

      // Both ports at once: port 1 wins and the error latches.
      cyc(0, 2'b11, 64'h11, 64'h22, 0, 1, 0, 1);
      idle(4, 1);

      // hold with two entries queued: nothing taken, FIFO drains.
      cyc(0, 2'b01, 64'h31, 0, 0, 0, 0, 0);
      cyc(0, 2'b10, 0, 64'h32, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 2'b01, 64'h33, 0, 0, 0, 1, 1);

      // Reset with three entries resident.
      for (int i = 0; i < 3; i++) cyc(0, 2'b01, 64'(i + 64'h40), 0, 0, 0, 0, 0);
      check("pre_reset_depth", 65'(q.size()), 65'd3);
      cyc(1, 2'b00, 0, 0, 0, 0, 0, 0);
      idle(2, 0);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         logic [1:0] ne;
         ne = 2'($urandom_range(0, 3));
         cyc(($urandom_range(0, 99) == 0), ne,
             {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), 1'($urandom),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7));
      end

      // Drain with a bounded budget.
      for (int i = 0; i < 20 && q.size() != 0; i++) idle(1, 1);
      idle(1, 1);
      check("drained", 65'(q.size()), 65'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               checks, errors);
      $finish;
   end

endmodule
